// File: rtl/ksa_shared_add_sequencer.sv
// rtl/ksa_shared_add_sequencer.sv - two-requester serial adder sharing one Kogge-Stone chunk slice
//
// Purpose: arbitrates (round-robin) between two add requesters and runs each WIDTH-bit
// A+B+cin one CHUNK-bit slice per cycle through a single parallel-prefix adder, carrying
// between chunks in a register. Result is held on the response side until taken.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   reqN_valid/reqN_ready      request handshake for requester N (ready only in IDLE, granted side)
//   reqN_a, reqN_b, reqN_cin   requester N operands
//   rsp_valid/rsp_ready        response handshake
//   rsp_sum, rsp_cout, rsp_id  result, carry out of MSB, owning requester
//   busy                       high whenever an operation is in flight or awaiting pickup
module ksa_shared_add_sequencer #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id,
    output logic             busy
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LVL  = (CHUNK > 1) ? $clog2(CHUNK) : 0;

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
        $error("ksa_shared_add_sequencer: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              cout_q, cout_d;
    logic              id_q, id_d;
    logic              last_grant_q, last_grant_d;

    logic              grant;
    logic              any_valid;
    logic              accept;
    int                base;
    logic [CHUNK-1:0]  slice_a, slice_b, slice_sum;
    logic              slice_cout;
    logic [LVL:0][CHUNK-1:0] g_l, p_l;
    logic [CHUNK-1:0]  carries;

    // On a tie the requester that did not win last time gets the slot.
    assign any_valid  = req0_valid | req1_valid;
    assign grant      = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    assign accept     = (state_q == S_IDLE) & any_valid;
    // rst_n gating keeps ready low while reset is asserted, even with a valid pending.
    assign req0_ready = rst_n & accept & ~grant;
    assign req1_ready = rst_n & accept & grant;

    assign rsp_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign rsp_sum    = sum_q;
    assign rsp_cout   = cout_q;
    assign rsp_id     = id_q;

    assign base    = int'(idx_q) * CHUNK;
    assign slice_a = a_q[base +: CHUNK];
    assign slice_b = b_q[base +: CHUNK];

    // Kogge-Stone prefix over the slice. The carry-in is folded into bit 0's generate so
    // every prefix generate G[i] is directly the carry out of bit i.
    always_comb begin
        g_l      = '0;
        p_l      = '0;
        carries  = '0;
        g_l[0]   = slice_a & slice_b;
        p_l[0]   = slice_a ^ slice_b;
        g_l[0][0] = g_l[0][0] | (p_l[0][0] & carry_q);
        for (int l = 0; l < LVL; l++) begin
            for (int i = 0; i < CHUNK; i++) begin
                if (i >= (1 << l)) begin
                    g_l[l+1][i] = g_l[l][i] | (p_l[l][i] & g_l[l][i-(1<<l)]);
                    p_l[l+1][i] = p_l[l][i] & p_l[l][i-(1<<l)];
                end else begin
                    g_l[l+1][i] = g_l[l][i];
                    p_l[l+1][i] = p_l[l][i];
                end
            end
        end
        for (int i = 0; i < CHUNK; i++) begin
            carries[i] = (i == 0) ? carry_q : g_l[LVL][i-1];
        end
    end

    assign slice_sum  = p_l[0] ^ carries;
    assign slice_cout = g_l[LVL][CHUNK-1];

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        idx_d        = idx_q;
        cout_d       = cout_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    a_d          = grant ? req1_a : req0_a;
                    b_d          = grant ? req1_b : req0_b;
                    carry_d      = grant ? req1_cin : req0_cin;
                    idx_d        = '0;
                    id_d         = grant;
                    last_grant_d = grant;
                    state_d      = S_CALC;
                end
            end
            S_CALC: begin
                sum_d[base +: CHUNK] = slice_sum;
                carry_d              = slice_cout;
                idx_d                = idx_q + 1'b1;
                if (idx_q == IDXW'(NCH - 1)) begin
                    cout_d  = slice_cout;
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            idx_q        <= '0;
            cout_q       <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
            carry_q      <= carry_d;
            idx_q        <= idx_d;
            cout_q       <= cout_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule
